// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and address helpers for the instruction cache.
// Line address = tag [15:9], index [8:4], word offset [3:1]; byte bit 0 is ignored.
package cache_pkg;

    localparam int TAG_W  = 7;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 3;
    localparam int LINES  = 32;
    localparam int WORDS  = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Data store: 32 lines x 8 words x 16 bits, one synchronous write and one combinational read port.
// Latency: write visible the cycle after wr_en; read is zero-cycle.
// Backpressure: none, both ports accept every cycle.
module cache_data_array
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [LINES*WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_idx, wr_off}] <= wr_dat;
        end
    end

    assign rd_dat = mem[{rd_idx, rd_off}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller with line fill from main memory.
// Latency: hits return in the same cycle; a miss fills 8 words then re-evaluates after one DONE cycle.
// Backpressure: cpu_stall holds the fetch on any miss and throughout FILL/DONE.
module icache_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid
);

    state_t state;
    state_t state_nxt;

    logic [TAG_W-1:0]       tag_arr [LINES];
    logic [LINES-1:0]       valid;
    logic [OFF_W-1:0]       issue_cnt;
    logic [OFF_W-1:0]       recv_cnt;
    logic [TAG_W+IDX_W-1:0] fill_line;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] rd_dat;
    logic              hit;
    logic              fill_wr;
    logic              fill_last;

    // Responses are counted rather than timed, so the controller is independent of memory latency.
    logic [31:0] unused_mem_lat;
    logic        unused_addr_b0;
    assign unused_mem_lat = MEM_LAT;
    assign unused_addr_b0 = cpu_addr[0];

    assign req_tag  = cpu_addr[ADDR_W-1:ADDR_W-TAG_W];
    assign req_idx  = cpu_addr[OFF_W+IDX_W:OFF_W+1];
    assign req_off  = cpu_addr[OFF_W:1];
    assign fill_tag = fill_line[TAG_W+IDX_W-1:IDX_W];
    assign fill_idx = fill_line[IDX_W-1:0];

    assign hit       = cpu_req & valid[req_idx] & (tag_arr[req_idx] == req_tag) & (state == ST_IDLE);
    assign cpu_stall = (cpu_req & ~hit) | (state != ST_IDLE);
    assign cpu_data  = hit ? rd_dat : '0;

    assign fill_wr   = (state == ST_FILL) & mem_data_valid;
    assign fill_last = fill_wr & (recv_cnt == LAST_WORD);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cpu_req && !hit) state_nxt = ST_FILL;
            ST_FILL: if (fill_last)       state_nxt = ST_DONE;
            ST_DONE:                      state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            valid     <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            fill_line <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_FILL) begin
                fill_line <= cpu_addr[ADDR_W-1:OFF_W+1];
                mem_addr  <= line_base(cpu_addr);
                mem_rd_en <= 1'b1;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end else if (state == ST_FILL && mem_rd_en) begin
                // issue_cnt parks at the last word so mem_addr stays on the final request
                if (issue_cnt == LAST_WORD) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    issue_cnt <= issue_cnt + OFF_W'(1);
                    mem_addr  <= mem_addr + ADDR_W'(2);
                end
            end
            if (fill_wr) begin
                recv_cnt <= recv_cnt + OFF_W'(1);
            end
            // A fill completing alongside a flush leaves just the new line valid.
            if (flush) begin
                valid <= '0;
            end
            if (fill_last) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_last) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

    cache_data_array u_data (
        .clk    (clk),
        .wr_en  (fill_wr),
        .wr_idx (fill_idx),
        .wr_off (recv_cnt),
        .wr_dat (mem_data),
        .rd_idx (req_idx),
        .rd_off (req_off),
        .rd_dat (rd_dat)
    );

endmodule
